// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply/divide unit for the EX stage
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, op_i            request and opcode (00 MUL, 01 MULU, 10 DIV, 11 DIVU)
//   opdata1_i, opdata2_i     multiplicand/dividend, multiplier/divisor
//   annul_i                  flush: abandons the operation in flight
//   result_o                 {hi, lo}: full product, or {remainder, quotient}
//   ready_o                  one-cycle pulse when result_o is updated
//   div_zero_o               divisor was zero (valid with ready_o)
//   busy_o                   iterating
//   stallreq_o               hold the pipeline while an operation is pending

module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 div_zero_o,
    output logic                 busy_o,
    output logic                 stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_div_r;   // 1: divide, 0: multiply
    logic               neg_lo_r;   // negate product (MUL) or quotient (DIV)
    logic               neg_hi_r;   // negate remainder (DIV)
    logic               dz_r;
    logic [WIDTH-1:0]   opnd_r;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi;     // MUL: running partial product; DIV: partial remainder
    logic [WIDTH-1:0]   acc_lo;     // MUL: multiplier bits shifting out; DIV: dividend in / quotient out

    // Operand magnitudes at acceptance time
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;

    // Sign fix-up applied when the result is registered
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & opdata1_i[WIDTH-1];
        b_neg     = signed_op & opdata2_i[WIDTH-1];
        abs_a     = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        abs_b     = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
        accept    = (state == S_IDLE) & start_i & ~annul_i;
    end

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is set,
        // then the carry and sum shift right into the product register.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        // Restoring: bring the next dividend bit into the partial remainder and
        // subtract the divisor if it fits. The true difference is below the
        // divisor, so a WIDTH-bit subtraction is exact.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_r};
        div_sub   = div_shift[WIDTH-1:0] - opnd_r;
    end

    always_comb begin
        prod_fix = neg_lo_r ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        quot_fix = neg_lo_r ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = neg_hi_r ? (~acc_hi + 1'b1) : acc_hi;
    end

    assign stallreq_o = accept | (state == S_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_div_r   <= 1'b0;
            neg_lo_r   <= 1'b0;
            neg_hi_r   <= 1'b0;
            dz_r       <= 1'b0;
            opnd_r     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_div_r   <= op_i[1];
                        div_zero_o <= 1'b0;
                        cnt        <= CNT_W'(WIDTH);
                        if (op_i[1] && (opdata2_i == '0)) begin
                            // Divide by zero skips iteration; clearing the sign
                            // flags makes the fix-up pass the raw values through.
                            dz_r     <= 1'b1;
                            neg_lo_r <= 1'b0;
                            neg_hi_r <= 1'b0;
                            acc_hi   <= opdata1_i;
                            acc_lo   <= '1;
                            opnd_r   <= '0;
                            state    <= S_DONE;
                        end else begin
                            dz_r     <= 1'b0;
                            neg_lo_r <= a_neg ^ b_neg;
                            neg_hi_r <= a_neg;
                            acc_hi   <= '0;
                            acc_lo   <= op_i[1] ? abs_a : abs_b;
                            opnd_r   <= op_i[1] ? abs_b : abs_a;
                            busy_o   <= 1'b1;
                            state    <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (annul_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        if (op_div_r) begin
                            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            busy_o <= 1'b0;
                            state  <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // start_i is ignored here; annul suppresses the result
                    state <= S_IDLE;
                    if (!annul_i) begin
                        ready_o    <= 1'b1;
                        div_zero_o <= dz_r;
                        result_o   <= op_div_r ? {rem_fix, quot_fix} : prod_fix;
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8

module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0, annul32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] result32;
    logic        ready32, dz32, busy32, stall32;

    logic        start8 = 1'b0, annul8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] result8;
    logic        ready8, dz8, busy8, stall8;

    mdu_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op32),
        .opdata1_i(a32), .opdata2_i(b32), .annul_i(annul32),
        .result_o(result32), .ready_o(ready32), .div_zero_o(dz32),
        .busy_o(busy32), .stallreq_o(stall32)
    );

    mdu_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
        .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
        .result_o(result8), .ready_o(ready8), .div_zero_o(dz8),
        .busy_o(busy8), .stallreq_o(stall8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        longint      cyc;
    } exp_t;

    exp_t        sb32[$];
    exp_t        sb8[$];
    exp_t        e32, e8;
    longint      cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res32 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned arithmetic on 64-bit integers, packed as {hi, lo}
    function automatic logic [63:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub, p, q, r;
        longint          sa, sb;
        m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
        ua = {32'b0, a} & m;
        ub = {32'b0, b} & m;
        sa = longint'(ua);
        sb = longint'(ub);
        if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
        if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
        if (!op[1]) begin
            p = op[0] ? (ua * ub) : longint'(sa * sb);
            return (w == 32) ? p : (p & 64'hFFFF);
        end
        if (ub == 0) return (ua << w) | m;
        if (op[0]) begin
            q = ua / ub;
            r = ua % ub;
        end else begin
            q = longint'(sa / sb);
            r = longint'(sa % sb);
        end
        return ((r & m) << w) | (q & m);
    endfunction

    always @(negedge clk) begin
        if (!rst && ready32) begin
            if (sb32.size() == 0) chk("unexpected_ready32", 64'd1, 64'd0);
            else begin
                e32 = sb32.pop_front();
                chk("result32", result32, e32.res);
                chk("div_zero32", {63'b0, dz32}, {63'b0, e32.dz});
                chk("ready_cycle32", cyc, e32.cyc);
                last_res32 = e32.res;
            end
        end
        if (!rst && ready8) begin
            if (sb8.size() == 0) chk("unexpected_ready8", 64'd1, 64'd0);
            else begin
                e8 = sb8.pop_front();
                chk("result8", {48'b0, result8}, e8.res);
                chk("div_zero8", {63'b0, dz8}, {63'b0, e8.dz});
                chk("ready_cycle8", cyc, e8.cyc);
            end
        end
    end

    // Issue one operation on the selected instance; hold keeps start_i high until ready.
    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        exp_t e;
        int   w, st, lat;
        bit   seen, dz;
        w   = w8 ? 8 : 32;
        dz  = op[1] && (w8 ? (b[7:0] == 8'd0) : (b == 32'd0));
        lat = dz ? 1 : w + 1;
        st  = 0;
        seen = 0;
        @(negedge clk);
        if (w8) begin start8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin start32 = 1; op32 = op; a32 = a; b32 = b; end
        #1 st += int'(w8 ? stall8 : stall32);
        @(posedge clk);
        #1;
        e.res = model(w, op, a, b);
        e.dz  = dz;
        e.cyc = cyc + lat;
        if (w8) sb8.push_back(e); else sb32.push_back(e);
        chk(w8 ? "dz_clear8" : "dz_clear32", {63'b0, (w8 ? dz8 : dz32)}, 64'd0);
        // operands are scrambled after acceptance
        if (w8) begin a8 = 8'($urandom); b8 = 8'($urandom); start8 = hold; end
        else    begin a32 = $urandom; b32 = $urandom; start32 = hold; end
        for (int i = 0; i < w + 8; i++) begin
            @(negedge clk);
            if (w8 ? ready8 : ready32) begin seen = 1; break; end
            st += int'(w8 ? stall8 : stall32);
        end
        start8 = 0;
        start32 = 0;
        chk(w8 ? "ready_seen8" : "ready_seen32", {63'b0, seen}, 64'd1);
        chk(w8 ? "stall_cycles8" : "stall_cycles32", 64'(st), 64'(dz ? 1 : w + 1));
        if (hold) begin
            @(posedge clk);
            #1 chk(w8 ? "no_retrigger8" : "no_retrigger32", {63'b0, (w8 ? busy8 : busy32)}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          kind;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result32, 64'd0);
        chk("reset_ready", {63'b0, ready32}, 64'd0);
        chk("reset_dz", {63'b0, dz32}, 64'd0);
        chk("reset_busy", {63'b0, busy32}, 64'd0);
        chk("reset_stall", {63'b0, stall32}, 64'd0);
        chk("reset_result8", {48'b0, result8}, 64'd0);
        rst = 0;

        run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(0, 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(0, 2'b11, 32'd100, 32'd0, 0);
        run_op(0, 2'b11, 32'd100, 32'd7, 0);
        run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1, 2'b10, 32'h0000_0080, 32'd3, 1);
        run_op(1, 2'b10, 32'h0000_0085, 32'd0, 1);

        // Annul in the tenth BUSY cycle
        @(negedge clk);
        start32 = 1; op32 = 2'b11; a32 = $urandom; b32 = 32'd5;
        @(posedge clk);
        #1 start32 = 0;
        repeat (10) @(negedge clk);
        annul32 = 1;
        @(posedge clk);
        #1 annul32 = 0;
        chk("annul_busy", {63'b0, busy32}, 64'd0);
        chk("annul_ready", {63'b0, ready32}, 64'd0);
        chk("annul_result_held", result32, last_res32);
        run_op(0, 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 0);

        // Annul on an IDLE start is not accepted
        @(negedge clk);
        start32 = 1; annul32 = 1;
        #1 chk("annul_idle_stall", {63'b0, stall32}, 64'd0);
        @(posedge clk);
        #1 start32 = 0; annul32 = 0;
        chk("annul_idle_busy", {63'b0, busy32}, 64'd0);

        // Reset in the middle of BUSY
        @(negedge clk);
        start32 = 1; op32 = 2'b00; a32 = $urandom; b32 = $urandom;
        @(posedge clk);
        #1 start32 = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("midrst_result", result32, 64'd0);
        chk("midrst_ready", {63'b0, ready32}, 64'd0);
        chk("midrst_dz", {63'b0, dz32}, 64'd0);
        chk("midrst_busy", {63'b0, busy32}, 64'd0);
        @(negedge clk);
        rst = 0;
        last_res32 = '0;

        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 5);
            a    = $urandom;
            b    = $urandom;
            if (kind == 0) b = 32'd0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) begin a = 32'($signed($urandom_range(0, 40)) - 20); b = 32'($urandom_range(1, 9)); end
            if (n % 3 == 2) begin
                if (kind == 1) begin a = 32'h80; b = 32'hFF; end
                run_op(1, op, a, b, n[0]);
            end else begin
                run_op(0, op, a, b, n[0]);
            end
        end

        repeat (3) @(negedge clk);
        chk("sb32_drained", 64'(sb32.size()), 64'd0);
        chk("sb8_drained", 64'(sb8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
